// File: rtl/t03_text_scanout_if.sv
// Handshake and data bundle between the text lookup / display writer and the
// pixel scan-out engine.
interface t03_text_scanout_if #(
  parameter int NUMBER_OF_CHARS = 12,
  parameter int X_LENGTH        = 9,
  parameter int Y_LENGTH        = 8,
  parameter int COLOR_W         = 16
);
  localparam int LINE_W = NUMBER_OF_CHARS * X_LENGTH;
  localparam int TOTAL  = LINE_W * Y_LENGTH;
  localparam int X_W    = $clog2(LINE_W);
  localparam int Y_W    = $clog2(Y_LENGTH);

  logic               start;
  logic [TOTAL-1:0]   characters;
  logic [COLOR_W-1:0] fg_color;
  logic [COLOR_W-1:0] bg_color;
  logic               pixel_ready;
  logic               pixel_valid;
  logic [COLOR_W-1:0] pixel_color;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic               row_last;
  logic               busy;
  logic               done;

  modport master (
    output start, characters, fg_color, bg_color, pixel_ready,
    input  pixel_valid, pixel_color, pixel_x, pixel_y, row_last, busy, done
  );

  modport slave (
    input  start, characters, fg_color, bg_color, pixel_ready,
    output pixel_valid, pixel_color, pixel_x, pixel_y, row_last, busy, done
  );
endinterface

// File: rtl/t03_text_scanout.sv
// Raster-order pixel scan-out of a snapshotted glyph-bitmap line, one pixel
// per valid/ready transfer, with foreground/background colour applied.
module t03_text_scanout #(
  parameter int NUMBER_OF_CHARS = 12,
  parameter int X_LENGTH        = 9,
  parameter int Y_LENGTH        = 8,
  parameter int COLOR_W         = 16
) (
  input logic              clk,
  input logic              rst,
  t03_text_scanout_if.slave bus
);
  localparam int LINE_W = NUMBER_OF_CHARS * X_LENGTH;
  localparam int TOTAL  = LINE_W * Y_LENGTH;
  localparam int X_W    = $clog2(LINE_W);
  localparam int Y_W    = $clog2(Y_LENGTH);
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [TOTAL-1:0]   shadow_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;

  logic               load;
  logic               xfer;
  logic               at_row_end;
  logic               at_last;

  logic               pixel_valid_c;
  logic [COLOR_W-1:0] pixel_color_c;
  logic [X_W-1:0]     pixel_x_c;
  logic [Y_W-1:0]     pixel_y_c;
  logic               row_last_c;
  logic               busy_c;
  logic               done_c;

  assign load       = (state_q == IDLE) && bus.start;
  assign xfer       = (state_q == SCAN) && bus.pixel_ready;
  assign at_row_end = (x_q == X_LAST);
  assign at_last    = at_row_end && (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (xfer && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shadow is consumed MSB-first: each accepted pixel shifts the next
  // raster bit into the top position, so the current pixel is always bit TOTAL-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (load) begin
      shadow_q <= bus.characters;
      fg_q     <= bus.fg_color;
      bg_q     <= bus.bg_color;
      x_q      <= '0;
      y_q      <= '0;
    end else if (xfer) begin
      shadow_q <= {shadow_q[TOTAL-2:0], 1'b0};
      if (at_row_end) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Every output is a pure decode of registered state, and all pixel fields
  // read zero whenever no pixel is being offered.
  always_comb begin
    pixel_valid_c = 1'b0;
    pixel_color_c = '0;
    pixel_x_c     = '0;
    pixel_y_c     = '0;
    row_last_c    = 1'b0;
    busy_c        = (state_q != IDLE);
    done_c        = (state_q == DONE);
    if (state_q == SCAN) begin
      pixel_valid_c = 1'b1;
      pixel_color_c = shadow_q[TOTAL-1] ? fg_q : bg_q;
      pixel_x_c     = x_q;
      pixel_y_c     = y_q;
      row_last_c    = at_row_end;
    end
  end

  assign bus.pixel_valid = pixel_valid_c;
  assign bus.pixel_color = pixel_color_c;
  assign bus.pixel_x     = pixel_x_c;
  assign bus.pixel_y     = pixel_y_c;
  assign bus.row_last    = row_last_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
endmodule

// File: tb/tb_t03_text_scanout.sv
// Bench for the text pixel scan-out engine, checked against a raster-order
// model that indexes the latched bitmap directly by pixel number.
module tb_t03_text_scanout;
  localparam int NC     = 12;
  localparam int XL     = 9;
  localparam int YL     = 8;
  localparam int CW     = 16;
  localparam int LINE_W = NC * XL;
  localparam int TOTAL  = LINE_W * YL;
  localparam int X_W    = $clog2(LINE_W);
  localparam int Y_W    = $clog2(YL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [TOTAL-1:0] m_chars;
  logic [CW-1:0]    m_fg;
  logic [CW-1:0]    m_bg;

  t03_text_scanout_if #(.NUMBER_OF_CHARS(NC), .X_LENGTH(XL), .Y_LENGTH(YL), .COLOR_W(CW)) bus ();

  t03_text_scanout #(.NUMBER_OF_CHARS(NC), .X_LENGTH(XL), .Y_LENGTH(YL), .COLOR_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ref_color(input int n);
    return m_chars[TOTAL-1-n] ? m_fg : m_bg;
  endfunction

  function automatic logic [TOTAL-1:0] rand_bits();
    logic [TOTAL-1:0] v;
    for (int i = 0; i < TOTAL; i++) v[i] = 1'($urandom_range(1));
    return v;
  endfunction

  task automatic start_scan(input logic [TOTAL-1:0] ch, input logic [CW-1:0] fg,
                            input logic [CW-1:0] bg, input bit hold_start);
    bus.characters = ch;
    bus.fg_color   = fg;
    bus.bg_color   = bg;
    m_chars = ch;
    m_fg    = fg;
    m_bg    = bg;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
  endtask

  // Consumes one scan from its first offered pixel; checks each cycle against
  // the model pixel n, so any change during a stall is caught too.
  task automatic scan_and_check(input int ready_pct, input int mutate_at,
                                input int abort_at, input string tag);
    int n = 0;
    int cycles = 0;
    int rl_count = 0;
    bit rdy;
    bit mutated = 0;
    bit obs_rl;
    logic [X_W-1:0] ex;
    logic [Y_W-1:0] ey;
    logic [CW-1:0]  ec;
    logic           erl;
    while (n < TOTAL) begin
      if (cycles > 20 * TOTAL) begin
        n_cmp++; n_err++;
        $display("FAIL %s timeout: only %0d of %0d pixels accepted", tag, n, TOTAL);
        return;
      end
      ex  = X_W'(n % LINE_W);
      ey  = Y_W'(n / LINE_W);
      ec  = ref_color(n);
      erl = ((n % LINE_W) == LINE_W - 1);
      n_cmp++;
      if (bus.pixel_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s ctrl at pixel %0d: valid=%b busy=%b done=%b, want 1 1 0",
                 tag, n, bus.pixel_valid, bus.busy, bus.done);
      end
      n_cmp++;
      if (bus.pixel_x !== ex || bus.pixel_y !== ey) begin
        n_err++;
        $display("FAIL %s coord at pixel %0d: got (%0d,%0d) want (%0d,%0d)",
                 tag, n, bus.pixel_x, bus.pixel_y, ex, ey);
      end
      n_cmp++;
      if (bus.pixel_color !== ec) begin
        n_err++;
        $display("FAIL %s color at pixel %0d: got %h want %h", tag, n, bus.pixel_color, ec);
      end
      n_cmp++;
      if (bus.row_last !== erl) begin
        n_err++;
        $display("FAIL %s row_last at pixel %0d: got %b want %b", tag, n, bus.row_last, erl);
      end
      if (n == mutate_at && !mutated) begin
        bus.characters = ~bus.characters;
        bus.fg_color   = ~m_fg;
        bus.bg_color   = ~m_bg;
        mutated = 1;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.row_last !== 1'b0) begin
          n_err++;
          $display("FAIL %s after reset: valid=%b busy=%b done=%b row_last=%b, want all 0",
                   tag, bus.pixel_valid, bus.busy, bus.done, bus.row_last);
        end
        return;
      end
      obs_rl = bus.row_last;
      rdy = ($urandom_range(99) < ready_pct);
      bus.pixel_ready = rdy;
      @(posedge clk); #1;
      cycles++;
      if (rdy) begin
        if (obs_rl) rl_count++;
        n++;
      end
    end
    bus.pixel_ready = 1'b1;
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.pixel_valid !== 1'b0 ||
        bus.pixel_color !== '0 || bus.pixel_x !== '0 || bus.pixel_y !== '0 ||
        bus.row_last !== 1'b0) begin
      n_err++;
      $display("FAIL %s done cycle: done=%b busy=%b valid=%b color=%h x=%0d y=%0d rl=%b, want 1 1 0 0 0 0 0",
               tag, bus.done, bus.busy, bus.pixel_valid, bus.pixel_color,
               bus.pixel_x, bus.pixel_y, bus.row_last);
    end
    n_cmp++;
    if (rl_count != YL) begin
      n_err++;
      $display("FAIL %s row_last count: got %0d want %0d", tag, rl_count, YL);
    end
    if (ready_pct >= 100) begin
      n_cmp++;
      if (cycles != TOTAL) begin
        n_err++;
        $display("FAIL %s scan length: got %0d cycles want %0d", tag, cycles, TOTAL);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pixel_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle after done: busy=%b done=%b valid=%b, want 0 0 0",
               tag, bus.busy, bus.done, bus.pixel_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start       = 1'b1;
    bus.characters  = rand_bits();
    bus.fg_color    = CW'($urandom);
    bus.bg_color    = CW'($urandom);
    bus.pixel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.pixel_color !== '0 || bus.pixel_x !== '0 || bus.pixel_y !== '0 ||
        bus.row_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset outputs: valid=%b busy=%b done=%b color=%h x=%0d y=%0d rl=%b, want all 0",
               bus.pixel_valid, bus.busy, bus.done, bus.pixel_color,
               bus.pixel_x, bus.pixel_y, bus.row_last);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset idle: busy=%b valid=%b, want 0 0", bus.busy, bus.pixel_valid);
    end
  endtask

  task automatic test_glyph_a();
    logic [XL-1:0]    glyph [YL];
    logic [CW-1:0]    row0 [XL];
    logic [TOTAL-1:0] ch;
    logic [CW-1:0]    want;
    int               cyc = 0;
    glyph = '{9'b001110000, 9'b010001000, 9'b100000100, 9'b100000100,
              9'b111111100, 9'b100000100, 9'b100000100, 9'b000000000};
    row0  = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    ch = '0;
    for (int r = 0; r < YL; r++)
      for (int k = 0; k < XL; k++)
        ch[TOTAL-1-(r*LINE_W+k)] = glyph[r][XL-1-k];
    bus.pixel_ready = 1'b1;
    start_scan(ch, 16'hFFFF, 16'h0000, 0);
    while (bus.pixel_valid === 1'b1 && cyc < TOTAL + 4) begin
      if (cyc < LINE_W) begin
        want = (cyc < XL) ? row0[cyc] : 16'h0000;
        n_cmp++;
        if (bus.pixel_color !== want || bus.pixel_x !== X_W'(cyc) || bus.pixel_y !== '0) begin
          n_err++;
          $display("FAIL glyph_a row0 x=%0d: got color=%h x=%0d y=%0d want %h %0d 0",
                   cyc, bus.pixel_color, bus.pixel_x, bus.pixel_y, want, cyc);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != TOTAL || bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL glyph_a transfers: got %0d cycles done=%b want %0d done=1", cyc, bus.done, TOTAL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_checkerboard();
    logic [TOTAL-1:0] ch;
    for (int i = 0; i < TOTAL; i++) ch[i] = 1'(i % 2);
    start_scan(ch, CW'($urandom), CW'($urandom), 0);
    scan_and_check(50, -1, -1, "checker");
  endtask

  task automatic test_midscan_change();
    start_scan(rand_bits(), CW'($urandom), CW'($urandom), 0);
    scan_and_check(75, 300, -1, "midscan");
  endtask

  task automatic test_back_to_back();
    start_scan(rand_bits(), CW'($urandom), CW'($urandom), 1);
    scan_and_check(100, -1, -1, "b2b_first");
    @(posedge clk); #1;
    bus.start = 1'b0;
    scan_and_check(70, -1, -1, "b2b_second");
  endtask

  task automatic test_reset_midscan();
    start_scan(rand_bits(), CW'($urandom), CW'($urandom), 0);
    scan_and_check(80, -1, 3 * LINE_W + 50, "rst_mid");
    start_scan(rand_bits(), CW'($urandom), CW'($urandom), 0);
    scan_and_check(100, -1, -1, "rst_rescan");
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.characters  = '0;
    bus.fg_color    = '0;
    bus.bg_color    = '0;
    bus.pixel_ready = 1'b1;
    m_chars = '0;
    m_fg    = '0;
    m_bg    = '0;
    test_reset();
    test_glyph_a();
    test_checkerboard();
    test_midscan_change();
    test_back_to_back();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/t03_text_scanout.md
# t03_text_scanout

Pixel scan-out engine for the text overlay. It snapshots the packed glyph-bitmap bus produced by the text lookup stage and streams one pixel per accepted transfer, in raster order, to the display writer. Pixels go out row by row across all character cells, with foreground/background colour applied. It sits between the text lookup and the framebuffer/display write path, and uses a valid/ready handshake so the display side can stall it.

## Interface
Parameters:
- NUMBER_OF_CHARS, 12, character cells per text line
- X_LENGTH, 9, glyph width in pixels
- Y_LENGTH, 8, glyph height in pixels
- COLOR_W, 16, pixel colour width (RGB565)
- Derived, not overridable:
  - LINE_W = NUMBER_OF_CHARS*X_LENGTH (108)
  - TOTAL = LINE_W*Y_LENGTH (864)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new scan; sampled only in IDLE
- characters  in  TOTAL  packed glyph bitmaps. Pixel (x, y) is bit TOTAL-1-(y*LINE_W+x). Row y of cell i, column k is at x = i*X_LENGTH+k, so each row is contiguous and MSB-first.
- fg_color  in  COLOR_W  colour for set bits; latched at start
- bg_color  in  COLOR_W  colour for clear bits; latched at start
- pixel_ready  in  1  downstream accepts the current pixel
- pixel_valid  out  1  pixel_color/pixel_x/pixel_y are valid
- pixel_color  out  COLOR_W  fg_color if the bitmap bit is 1, else bg_color
- pixel_x  out  $clog2(LINE_W)  column, 0..LINE_W-1
- pixel_y  out  $clog2(Y_LENGTH)  row, 0..Y_LENGTH-1
- row_last  out  1  current pixel is x = LINE_W-1
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1: latch characters, fg_color and bg_color into shadow registers; clear x and y; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - pixel_valid=1.
  - Outputs come from the shadow copy only. Input changes during a scan have no effect.
  - Transfer occurs when pixel_valid & pixel_ready.
  - On transfer:
    - If x < LINE_W-1: x++.
    - Else: x = 0, y++.
  - Transfer at x = LINE_W-1, y = Y_LENGTH-1: go to DONE.
  - No transfer: pixel_valid, pixel_color, pixel_x, pixel_y and row_last hold stable.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored, not queued.
- row_last = (x == LINE_W-1) & pixel_valid.
- Outputs are don't-care-free: when pixel_valid=0, pixel_color=0, pixel_x=0, pixel_y=0, row_last=0.
- Reset (any state, including mid-scan):
  - state = IDLE; x, y, pixel_valid, busy, done and row_last all 0; shadow registers cleared.
  - The next scan must begin from pixel (0,0).

## Timing
- start sampled high at edge T0: pixel_valid=1 with pixel (0,0) from cycle T0+1. Latency is 1 cycle, and outputs are registered.
- Throughput is 1 pixel/cycle when pixel_ready is held high. The last pixel is presented at T0+TOTAL (T0+864).
- DONE (done=1, busy=1) at T0+TOTAL+1. IDLE (busy=0) at T0+TOTAL+2. The earliest accepted restart is start sampled at T0+TOTAL+2.
- Each cycle with pixel_ready=0 adds exactly one cycle to every later event.
- pixel_ready may toggle arbitrarily. pixel_valid is never deasserted in SCAN until the final transfer.

## Test plan
- Glyph 'A' in cell 0, other cells zero; fg=16'hFFFF, bg=16'h0000; ready=1; start at T0.
  - Row 0, x=0..8 outputs 0,0,FFFF,FFFF,FFFF,0,0,0,0.
  - x=9..107 output 0.
  - Exactly 864 transfers, done at T0+865.
- Checkerboard characters pattern (alternating bits), random pixel_ready at 50%.
  - Accepted pixel sequence equals the bus bits MSB-first, mapped to fg/bg.
  - pixel_x/pixel_y step 0..107 / 0..7 with no skips or repeats.
  - Outputs hold stable during stalls.
- Change characters and fg_color mid-scan (at pixel 300).
  - Every remaining pixel still reflects the values latched at start.
- start asserted every cycle during a scan.
  - Exactly one done pulse per scan. Second scan starts at T0+866, with pixel_valid at T0+867.
- rst pulsed at pixel (50,3).
  - Next cycle: pixel_valid=0, busy=0, done=0.
  - A new start yields pixel (0,0) first and a full 864-pixel scan.
- Check row_last at every row boundary.
  - row_last=1 only at x=107: 8 times per scan, with y incrementing on the following transfer.
